seg7_scan: RTL



---
 rtl/seg7_pkg.sv | 19 +
 rtl/hex_to_seg7.sv | 15 +
 rtl/seg7_scan.sv | 79 +++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit multiplexed 7-segment driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Segment encoding is active-low {g,f,e,d,c,b,a} for a common-anode bank.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // Nibble-to-segment table; entry n sits at HEX_SEG_TABLE[n].
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: i_nibble - 4-bit hex digit; o_seg - segments {g..a}, active-low.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan.sv
// Latches a 32-bit value and scans it as 8 hex digits onto a common-anode display.
// Latency: outputs registered, one cycle after the idx/shown state they reflect.
// Backpressure: none; load is accepted every cycle, the scan free-runs.
//
// Ports: clk, rst (sync, active-high); data_in/load capture the value;
// blank_lz enables leading-zero blanking; dp_en per-digit decimal points;
// an/seg/dp drive the display pins, all active-low.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned DIV_W   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           data_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  logic [31:0]           r_shown;
  logic [DIV_W-1:0]      r_pcnt;
  logic [2:0]            r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tick;
  logic [4:0]            w_bit_base;
  logic [31:0]           w_upper;
  logic                  w_blank;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;

  assign w_tick     = (r_pcnt == DIV_W'(CLK_DIV - 1));
  assign w_bit_base = {r_idx, 2'b00};

  // Everything from the current digit upward; zero means this digit is a leading zero.
  assign w_upper  = r_shown >> w_bit_base;
  // Digit 0 is never blanked so an all-zero value still shows a single "0".
  assign w_blank  = blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0);
  assign w_nibble = r_shown[w_bit_base +: 4];

  hex_to_seg7 u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shown <= 32'd0;
      r_pcnt  <= '0;
      r_idx   <= 3'd0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + DIV_W'(1);
      if (w_tick) begin
        r_idx <= r_idx + 3'd1;
      end
      if (load) begin
        r_shown <= data_in;
      end
      r_an  <= w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_seg;
      r_dp  <= ~dp_en[r_idx];
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
